// File: rtl/ascon_round_ctrl_pkg.sv
`default_nettype none
// ascon_round_ctrl_pkg: operation codes, FSM states and round/pad constants
// shared by the Ascon round controller and its round counter. Rev 1.0
package ascon_round_ctrl_pkg;

  localparam int PAD_AW            = 4;
  localparam int ROUND_WIDTH       = 4;
  localparam int MAX_ROUNDS        = 12;
  localparam int PA_ROUNDS_DEFAULT = 12;
  localparam int PB_ROUNDS_DEFAULT = 6;

  // A 64-bit rate block holds 8 bytes; index 8 means no padding in this block.
  localparam logic [PAD_AW-1:0] PAD_FULL = PAD_AW'(8);

  typedef enum logic [3:0] {
    OP_NONE      = 4'd0,
    OP_INIT      = 4'd1,
    OP_INIT_KEY  = 4'd2,
    OP_AD_ABSORB = 4'd3,
    OP_PERM      = 4'd4,
    OP_DOMSEP    = 4'd5,
    OP_DATA      = 4'd6,
    OP_FINAL     = 4'd7,
    OP_TAG       = 4'd8
  } ascon_op_e;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INIT_LOAD  = 4'd1,
    ST_INIT_PERM  = 4'd2,
    ST_INIT_KEY   = 4'd3,
    ST_AD_WAIT    = 4'd4,
    ST_AD_ABSORB  = 4'd5,
    ST_AD_PERM    = 4'd6,
    ST_DOMSEP     = 4'd7,
    ST_MSG_WAIT   = 4'd8,
    ST_MSG_OUT    = 4'd9,
    ST_MSG_PERM   = 4'd10,
    ST_FINAL_KEY  = 4'd11,
    ST_FINAL_PERM = 4'd12,
    ST_TAG        = 4'd13
  } ctrl_state_e;

  // Reduced-round permutations use the tail of the 12-entry constant table.
  function automatic logic [ROUND_WIDTH-1:0] first_round(input int rounds);
    return ROUND_WIDTH'(MAX_ROUNDS - rounds);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round_cnt.sv
`default_nettype none
// ascon_round_cnt: loadable round-constant index counter with last-round flag,
// shared by the pa and pb permutation phases. Rev 1.0
module ascon_round_cnt
  import ascon_round_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [ROUND_WIDTH-1:0] start_idx,
  input  logic                   step,
  output logic [ROUND_WIDTH-1:0] round,
  output logic                   done
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      round <= '0;
    end else if (load) begin
      round <= start_idx;
    end else if (step) begin
      round <= round + 1'b1;
    end
  end

  assign done = (round == ROUND_WIDTH'(MAX_ROUNDS - 1));

endmodule
`default_nettype wire

// File: rtl/ascon_round_ctrl.sv
`default_nettype none
// ascon_round_ctrl: Ascon-128 AEAD phase sequencer driving ascon_round_unit.
// Optional abort input enabled by ASCON_CTRL_ABORT_EN. Rev 1.0
module ascon_round_ctrl
  import ascon_round_ctrl_pkg::*;
#(
  parameter int BLOCK_AW  = 8,
  parameter int PA_ROUNDS = PA_ROUNDS_DEFAULT,
  parameter int PB_ROUNDS = PB_ROUNDS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic                   ready_o,
  input  logic                   decrypt_i,
  input  logic [BLOCK_AW-1:0]    ad_blocks_i,
  input  logic [BLOCK_AW-1:0]    msg_blocks_i,
  input  logic [PAD_AW-1:0]      ad_pad_idx_i,
  input  logic [PAD_AW-1:0]      msg_pad_idx_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   tag_valid_o,
  output logic                   ru_en_o,
  output ascon_op_e              ru_op_o,
  output logic                   ru_decrypt_o,
  output logic [PAD_AW-1:0]      ru_pad_idx_o,
  output logic [BLOCK_AW-1:0]    ru_blk_no_o,
  output logic [ROUND_WIDTH-1:0] ru_round_o
);

  ctrl_state_e           state;
  ascon_op_e             op_r;
  logic                  ready_r, en_r, blk_ready_r, out_valid_r, tag_valid_r, decrypt_r;
  logic [BLOCK_AW-1:0]   ad_cnt, msg_cnt, blk_cnt;
  logic [PAD_AW-1:0]     ad_pad, msg_pad;

  logic                  abort_hit, msg_hs, in_ad, in_msg, in_perm, blk_last;
  logic                  rnd_load, rnd_step, rnd_clear, rnd_done;
  logic [ROUND_WIDTH-1:0] rnd_start, round;

`ifdef ASCON_CTRL_ABORT_EN
  assign abort_hit = abort_i && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign in_ad    = state inside {ST_AD_WAIT, ST_AD_ABSORB, ST_AD_PERM};
  assign in_msg   = state inside {ST_MSG_WAIT, ST_MSG_OUT, ST_MSG_PERM};
  assign in_perm  = state inside {ST_INIT_PERM, ST_AD_PERM, ST_MSG_PERM, ST_FINAL_PERM};
  // Equality (not <) so a full 2^BLOCK_AW-1 block count never wraps.
  assign blk_last = in_ad ? (blk_cnt == ad_cnt - 1'b1) : (blk_cnt == msg_cnt - 1'b1);
  // The output handshake must absorb in the same cycle, so it bypasses the registers.
  assign msg_hs   = (state == ST_MSG_OUT) && out_ready_i && !abort_hit;

  always_comb begin
    rnd_load  = 1'b0;
    rnd_start = first_round(PB_ROUNDS);
    case (state)
      ST_INIT_LOAD, ST_FINAL_KEY: begin
        rnd_load  = 1'b1;
        rnd_start = first_round(PA_ROUNDS);
      end
      ST_AD_ABSORB: rnd_load = 1'b1;
      ST_MSG_OUT:   rnd_load = msg_hs && !blk_last;
      default: ;
    endcase
  end

  assign rnd_step  = in_perm && !rnd_done;
  assign rnd_clear = abort_hit || (in_perm && rnd_done);

  ascon_round_cnt u_round_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (rnd_clear),
    .load      (rnd_load),
    .start_idx (rnd_start),
    .step      (rnd_step),
    .round     (round),
    .done      (rnd_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || abort_hit) begin
      state       <= ST_IDLE;
      ready_r     <= 1'b1;
      op_r        <= OP_NONE;
      en_r        <= 1'b0;
      blk_ready_r <= 1'b0;
      out_valid_r <= 1'b0;
      tag_valid_r <= 1'b0;
      decrypt_r   <= 1'b0;
      blk_cnt     <= '0;
      ad_cnt      <= '0;
      msg_cnt     <= '0;
      ad_pad      <= '0;
      msg_pad     <= '0;
    end else begin
      en_r        <= 1'b0;
      blk_ready_r <= 1'b0;
      case (state)
        ST_IDLE: if (start_i) begin
          decrypt_r   <= decrypt_i;
          ad_cnt      <= ad_blocks_i;
          msg_cnt     <= msg_blocks_i;
          ad_pad      <= ad_pad_idx_i;
          msg_pad     <= msg_pad_idx_i;
          tag_valid_r <= 1'b0;
          ready_r     <= 1'b0;
          state       <= ST_INIT_LOAD;
          op_r        <= OP_INIT;
          en_r        <= 1'b1;
        end
        ST_INIT_LOAD: begin
          state <= ST_INIT_PERM;
          op_r  <= OP_PERM;
          en_r  <= 1'b1;
        end
        ST_INIT_PERM: begin
          en_r <= 1'b1;
          if (rnd_done) begin
            state <= ST_INIT_KEY;
            op_r  <= OP_INIT_KEY;
          end
        end
        ST_INIT_KEY: begin
          if (ad_cnt != '0) begin
            state <= ST_AD_WAIT;
            op_r  <= OP_NONE;
          end else begin
            state <= ST_DOMSEP;
            op_r  <= OP_DOMSEP;
            en_r  <= 1'b1;
          end
        end
        ST_AD_WAIT: if (blk_valid_i) begin
          state       <= ST_AD_ABSORB;
          op_r        <= OP_AD_ABSORB;
          en_r        <= 1'b1;
          blk_ready_r <= 1'b1;
        end
        ST_AD_ABSORB: begin
          state <= ST_AD_PERM;
          op_r  <= OP_PERM;
          en_r  <= 1'b1;
        end
        ST_AD_PERM: begin
          en_r <= 1'b1;
          if (rnd_done) begin
            if (blk_last) begin
              blk_cnt <= '0;
              state   <= ST_DOMSEP;
              op_r    <= OP_DOMSEP;
            end else begin
              blk_cnt <= blk_cnt + 1'b1;
              state   <= ST_AD_WAIT;
              op_r    <= OP_NONE;
              en_r    <= 1'b0;
            end
          end
        end
        ST_DOMSEP: begin
          if (msg_cnt != '0) begin
            state <= ST_MSG_WAIT;
            op_r  <= OP_DATA;
          end else begin
            state <= ST_FINAL_KEY;
            op_r  <= OP_FINAL;
            en_r  <= 1'b1;
          end
        end
        ST_MSG_WAIT: if (blk_valid_i) begin
          state       <= ST_MSG_OUT;
          out_valid_r <= 1'b1;
        end
        ST_MSG_OUT: if (msg_hs) begin
          out_valid_r <= 1'b0;
          en_r        <= 1'b1;
          if (blk_last) begin
            blk_cnt <= '0;
            state   <= ST_FINAL_KEY;
            op_r    <= OP_FINAL;
          end else begin
            state <= ST_MSG_PERM;
            op_r  <= OP_PERM;
          end
        end
        ST_MSG_PERM: begin
          en_r <= 1'b1;
          if (rnd_done) begin
            blk_cnt <= blk_cnt + 1'b1;
            state   <= ST_MSG_WAIT;
            op_r    <= OP_DATA;
            en_r    <= 1'b0;
          end
        end
        ST_FINAL_KEY: begin
          state <= ST_FINAL_PERM;
          op_r  <= OP_PERM;
          en_r  <= 1'b1;
        end
        ST_FINAL_PERM: begin
          en_r <= 1'b1;
          if (rnd_done) begin
            state <= ST_TAG;
            op_r  <= OP_TAG;
          end
        end
        ST_TAG: begin
          state       <= ST_IDLE;
          op_r        <= OP_NONE;
          tag_valid_r <= 1'b1;
          ready_r     <= 1'b1;
          decrypt_r   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ru_pad_idx_o = PAD_FULL;
    if (state == ST_IDLE) begin
      ru_pad_idx_o = '0;
    end else if ((in_ad || in_msg) && blk_last) begin
      ru_pad_idx_o = in_ad ? ad_pad : msg_pad;
    end
  end

  assign ready_o      = ready_r;
  assign blk_ready_o  = blk_ready_r | msg_hs;
  assign out_valid_o  = out_valid_r;
  assign tag_valid_o  = tag_valid_r;
  assign ru_en_o      = en_r | msg_hs;
  assign ru_op_o      = op_r;
  assign ru_decrypt_o = decrypt_r;
  assign ru_blk_no_o  = blk_cnt;
  assign ru_round_o   = round;

endmodule
`default_nettype wire

// File: tb/tb_ascon_round_ctrl.sv
`default_nettype none
// tb_ascon_round_ctrl: directed jobs with an expected-cycle scoreboard for
// ascon_round_ctrl (default build, abort feature off). Rev 1.0
module tb_ascon_round_ctrl;
  import ascon_round_ctrl_pkg::*;

  localparam int BLOCK_AW = 8;

  logic                   clk = 1'b0;
  logic                   rst_n, start_i, ready_o, decrypt_i;
  logic [BLOCK_AW-1:0]    ad_blocks_i, msg_blocks_i;
  logic [PAD_AW-1:0]      ad_pad_idx_i, msg_pad_idx_i;
  logic                   blk_valid_i, blk_ready_o, out_valid_o, out_ready_i, tag_valid_o;
  logic                   ru_en_o, ru_decrypt_o;
  ascon_op_e              ru_op_o;
  logic [PAD_AW-1:0]      ru_pad_idx_o;
  logic [BLOCK_AW-1:0]    ru_blk_no_o;
  logic [ROUND_WIDTH-1:0] ru_round_o;

  always #5 clk = ~clk;

  ascon_round_ctrl #(.BLOCK_AW(BLOCK_AW), .PA_ROUNDS(12), .PB_ROUNDS(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_o(ready_o),
    .decrypt_i(decrypt_i), .ad_blocks_i(ad_blocks_i), .msg_blocks_i(msg_blocks_i),
    .ad_pad_idx_i(ad_pad_idx_i), .msg_pad_idx_i(msg_pad_idx_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .tag_valid_o(tag_valid_o),
    .ru_en_o(ru_en_o), .ru_op_o(ru_op_o), .ru_decrypt_o(ru_decrypt_o),
    .ru_pad_idx_o(ru_pad_idx_o), .ru_blk_no_o(ru_blk_no_o), .ru_round_o(ru_round_o)
  );

  typedef struct {
    ascon_op_e op;
    logic      en;
    logic      brdy;
    logic      ov;
    int        rnd;
    logic      pc;
    int        bno;
    int        pad;
    logic      ordy;
    logic      bv;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  logic exp_dec = 1'b0;
  logic hold_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ascon_op_e op, input logic en, input logic brdy = 1'b0,
                      input logic ov = 1'b0, input int rnd = 0, input logic pc = 1'b0,
                      input int bno = 0, input int pad = 0, input logic ordy = 1'b1,
                      input logic bv = 1'b1);
    exp_t e;
    e.op = op; e.en = en; e.brdy = brdy; e.ov = ov; e.rnd = rnd;
    e.pc = pc; e.bno = bno; e.pad = pad; e.ordy = ordy; e.bv = bv;
    q.push_back(e);
  endtask

  task automatic push_perm(input int n);
    for (int i = 0; i < n; i++) push(OP_PERM, 1'b1, 1'b0, 1'b0, 12 - n + i);
  endtask

  task automatic push_init();
    push(OP_INIT, 1'b1);
    push_perm(12);
    push(OP_INIT_KEY, 1'b1);
  endtask

  task automatic push_final();
    push(OP_FINAL, 1'b1);
    push_perm(12);
    push(OP_TAG, 1'b1);
  endtask

  task automatic push_ad(input int nb, input int pad);
    for (int b = 0; b < nb; b++) begin
      int pv = (b == nb - 1) ? pad : int'(PAD_FULL);
      push(OP_NONE, 1'b0, 1'b0, 1'b0, 0, 1'b1, b, pv);
      push(OP_AD_ABSORB, 1'b1, 1'b1, 1'b0, 0, 1'b1, b, pv);
      push_perm(6);
    end
  endtask

  // stall_blk: output side holds out_ready low stall_n cycles;
  // wait_blk: input side holds blk_valid low wait_n cycles.
  task automatic push_msg(input int nb, input int pad, input int stall_blk, input int stall_n,
                          input int wait_blk, input int wait_n);
    for (int b = 0; b < nb; b++) begin
      int pv = (b == nb - 1) ? pad : int'(PAD_FULL);
      for (int w = 0; w < ((b == wait_blk) ? wait_n : 0); w++)
        push(OP_DATA, 1'b0, 1'b0, 1'b0, 0, 1'b1, b, pv, 1'b1, 1'b0);
      push(OP_DATA, 1'b0, 1'b0, 1'b0, 0, 1'b1, b, pv);
      for (int s = 0; s < ((b == stall_blk) ? stall_n : 0); s++)
        push(OP_DATA, 1'b0, 1'b0, 1'b1, 0, 1'b1, b, pv, 1'b0);
      push(OP_DATA, 1'b1, 1'b1, 1'b1, 0, 1'b1, b, pv);
      if (b != nb - 1) push_perm(6);
    end
  endtask

  task automatic check_idle(input logic tagv);
    chk("idle_ready", 32'(ready_o), 32'd1);
    chk("idle_op", 32'(ru_op_o), 32'(OP_NONE));
    chk("idle_en", 32'(ru_en_o), 32'd0);
    chk("idle_blk_ready", 32'(blk_ready_o), 32'd0);
    chk("idle_out_valid", 32'(out_valid_o), 32'd0);
    chk("idle_tag_valid", 32'(tag_valid_o), 32'(tagv));
    chk("idle_decrypt", 32'(ru_decrypt_o), 32'd0);
    chk("idle_pad", 32'(ru_pad_idx_o), 32'd0);
    chk("idle_blk_no", 32'(ru_blk_no_o), 32'd0);
    chk("idle_round", 32'(ru_round_o), 32'd0);
  endtask

  task automatic start_job(input logic dec, input int ad, input int adp, input int msg, input int msgp);
    decrypt_i     = dec;
    ad_blocks_i   = BLOCK_AW'(ad);
    ad_pad_idx_i  = PAD_AW'(adp);
    msg_blocks_i  = BLOCK_AW'(msg);
    msg_pad_idx_i = PAD_AW'(msgp);
    start_i       = 1'b1;
    exp_dec       = dec;
  endtask

  // One entry per cycle; job inputs are scrambled to show they were latched.
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      step();
      if (!hold_start) start_i = 1'b0;
      e = q.pop_front();
      out_ready_i   = e.ordy;
      blk_valid_i   = e.bv;
      decrypt_i     = ~decrypt_i;
      ad_blocks_i   = BLOCK_AW'($urandom);
      msg_blocks_i  = BLOCK_AW'($urandom);
      ad_pad_idx_i  = PAD_AW'($urandom);
      msg_pad_idx_i = PAD_AW'($urandom);
      #1;
      chk("op", 32'(ru_op_o), 32'(e.op));
      chk("en", 32'(ru_en_o), 32'(e.en));
      chk("blk_ready", 32'(blk_ready_o), 32'(e.brdy));
      chk("out_valid", 32'(out_valid_o), 32'(e.ov));
      chk("busy_tag_valid", 32'(tag_valid_o), 32'd0);
      chk("busy_ready", 32'(ready_o), 32'd0);
      chk("decrypt", 32'(ru_decrypt_o), 32'(exp_dec));
      if (e.op == OP_PERM) chk("round", 32'(ru_round_o), 32'(e.rnd));
      if (e.pc) begin
        chk("blk_no", 32'(ru_blk_no_o), 32'(e.bno));
        chk("pad", 32'(ru_pad_idx_o), 32'(e.pad));
      end
    end
  endtask

  task automatic finish_job();
    step();
    start_i     = 1'b0;
    hold_start  = 1'b0;
    blk_valid_i = 1'b1;
    out_ready_i = 1'b1;
    check_idle(1'b1);
    step();
    chk("tag_hold", 32'(tag_valid_o), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; decrypt_i = 1'b0;
    ad_blocks_i = '0; msg_blocks_i = '0; ad_pad_idx_i = '0; msg_pad_idx_i = '0;
    blk_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) step();
    check_idle(1'b0);
    rst_n = 1'b1; blk_valid_i = 1'b1; out_ready_i = 1'b1;
    step();
    check_idle(1'b0);

    // Empty AD and message: 29 cycles from start to tag.
    start_job(1'b0, 0, 0, 0, 0);
    push_init(); push(OP_DOMSEP, 1'b1); push_final();
    drain(); finish_job();

    // Two AD blocks, start held high throughout to show it is ignored while busy.
    hold_start = 1'b1;
    start_job(1'b0, 2, 3, 0, 0);
    push_init(); push_ad(2, 3); push(OP_DOMSEP, 1'b1); push_final();
    drain(); finish_job();

    // Three message blocks, decrypt, output stall on block 1, input gap on block 2.
    start_job(1'b1, 0, 0, 3, 5);
    push_init(); push(OP_DOMSEP, 1'b1); push_msg(3, 5, 1, 5, 2, 2); push_final();
    drain(); finish_job();

    // Reset in the middle of AD_PERM abandons the job.
    start_job(1'b1, 2, 3, 0, 0);
    push_init();
    push(OP_NONE, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0, int'(PAD_FULL));
    push(OP_AD_ABSORB, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0, int'(PAD_FULL));
    for (int i = 0; i < 3; i++) push(OP_PERM, 1'b1, 1'b0, 1'b0, 6 + i);
    drain();
    rst_n = 1'b0;
    step();
    check_idle(1'b0);
    rst_n = 1'b1; blk_valid_i = 1'b1; out_ready_i = 1'b1;
    step();
    check_idle(1'b0);

    // Fresh job after reset: padding-only AD block plus one message block.
    start_job(1'b1, 1, 0, 1, 7);
    push_init(); push_ad(1, 0); push(OP_DOMSEP, 1'b1);
    push_msg(1, 7, -1, 0, -1, 0); push_final();
    drain(); finish_job();

    // Maximum block count must not wrap.
    start_job(1'b0, 255, 6, 0, 0);
    push_init(); push_ad(255, 6); push(OP_DOMSEP, 1'b1); push_final();
    drain(); finish_job();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
